// File: rtl/rle_capture_unit.sv
// Run-length capture engine for the on-chip logic analyser: compresses samples into
// {count, data} lines, keeping a circular before-trigger queue and a linear post-trigger area.
module rle_capture_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CNT_MAX  = 253,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned BT_LINES = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [DATA_W-1:0]       trig_value,
    input  logic [DATA_W-1:0]       trig_mask,
    input  logic                    trig_mode,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [CNT_W+DATA_W-1:0] mem_wdata,
    output logic                    armed,
    output logic                    triggered,
    output logic                    done,
    output logic [ADDR_W-1:0]       bt_tail
);

    localparam int unsigned LINE_W = CNT_W + DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST_M1 = ADDR_W'((1 << ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] ADDR_BT_END  = ADDR_W'(BT_LINES - 1);
    localparam logic [ADDR_W-1:0] ADDR_POST    = ADDR_W'(BT_LINES);
    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_POST  = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   cur_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;
    logic                armed_q;
    logic                triggered_q;
    logic                done_q;
    logic [ADDR_W-1:0]   bt_tail_q;

    logic extend_c;
    logic fire_c;

    // A sample extends the run only while it repeats and the count has headroom.
    always_comb begin
        extend_c = (data_in == cur_q) && (cnt_q < CNT_SAT);
        fire_c   = ((data_in & trig_mask) == (trig_value & trig_mask)) ^ trig_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            bt_tail_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        cur_q       <= data_in;
                        cnt_q       <= CNT_ONE;
                        addr_q      <= '0;
                        armed_q     <= 1'b1;
                        triggered_q <= 1'b0;
                        done_q      <= 1'b0;
                        state_q     <= ST_PRE;
                    end else if (state_q == ST_DONE) begin
                        done_q <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (fire_c || !extend_c) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= {cnt_q, cur_q};
                        cur_q       <= data_in;
                        cnt_q       <= CNT_ONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    if (fire_c) begin
                        bt_tail_q   <= addr_q;
                        addr_q      <= ADDR_POST;
                        triggered_q <= 1'b1;
                        state_q     <= ST_POST;
                    end else if (!extend_c) begin
                        addr_q <= (addr_q == ADDR_BT_END) ? '0 : addr_q + ADDR_W'(1);
                    end
                end
                ST_POST: begin
                    if (extend_c) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= {cnt_q, cur_q};
                        cur_q       <= data_in;
                        cnt_q       <= CNT_ONE;
                        if (addr_q == ADDR_LAST_M1) begin
                            armed_q <= 1'b0;
                            state_q <= ST_FINAL;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_FINAL: begin
                    // The last line carries the queue tail so the host can unroll the ring.
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ADDR_LAST;
                    mem_wdata_q <= {CNT_W'(0), DATA_W'(bt_tail_q)};
                    state_q     <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign bt_tail   = bt_tail_q;

endmodule

// File: tb/tb_rle_capture_unit.sv
// Directed bench for rle_capture_unit: hand-computed line contents, addresses and flags.
module tb_rle_capture_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] trig_value = '0;
    logic [15:0] trig_mask = '0;
    logic        trig_mode = 1'b0;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        armed;
    logic        triggered;
    logic        done;
    logic [5:0]  bt_tail;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int base;
    logic [23:0] tb_mem [64];

    rle_capture_unit dut (
        .clk(clk), .rst(rst), .arm(arm), .data_in(data_in),
        .trig_value(trig_value), .trig_mask(trig_mask), .trig_mode(trig_mode),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .armed(armed), .triggered(triggered), .done(done), .bt_tail(bt_tail)
    );

    always #5 clk = ~clk;

    // Log every write strobe away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            tb_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {mem_we, mem_addr, armed, triggered, done, bt_tail}, 32'h0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        // Reset and idle toggling: nothing may be written.
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_triggered", 32'(triggered), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_bt_tail", 32'(bt_tail), 32'h0);
        for (int i = 0; i < 50; i++) begin
            data_in = (i % 2 == 0) ? 16'h5A5A : 16'hA5A5;
            tick();
        end
        chk("idle_writes", 32'(wr_cnt), 32'h0);
        chk_all_zero("idle_outputs");

        // Constant zero: one saturated line after 253 samples.
        trig_mask = 16'hFFFF; trig_value = 16'hFFFF; trig_mode = 1'b0;
        data_in = 16'h0000;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_armed", 32'(armed), 32'h1);
        repeat (252) tick();
        chk("sat_no_write_yet", 32'(mem_we), 32'h0);
        tick();
        chk("sat_we", 32'(mem_we), 32'h1);
        chk("sat_addr", 32'(mem_addr), 32'h0);
        chk("sat_wdata", 32'(mem_wdata), 32'hFD0000);
        repeat (47) tick();
        chk("sat_write_count", 32'(wr_cnt), 32'h1);
        chk("sat_triggered", 32'(triggered), 32'h0);

        // Alternating samples wrap the before-trigger queue, then trigger.
        rst = 1'b1; tick(); rst = 1'b0;
        trig_value = 16'h00AA;
        data_in = 16'h0002;
        arm = 1'b1; tick(); arm = 1'b0;
        base = wr_cnt;
        for (int k = 1; k <= 30; k++) begin
            data_in = (k % 2 == 1) ? 16'h0001 : 16'h0002;
            tick();
        end
        chk("wrap_addr", 32'(mem_addr), 32'h5);
        chk("wrap_wdata", 32'(mem_wdata), 32'h010001);
        data_in = 16'h00AA;
        tick();
        chk("trig_we", 32'(mem_we), 32'h1);
        chk("trig_addr", 32'(mem_addr), 32'h6);
        chk("trig_wdata", 32'(mem_wdata), 32'h010002);
        chk("trig_flag", 32'(triggered), 32'h1);
        chk("trig_bt_tail", 32'(bt_tail), 32'h6);
        chk("wrap_count", 32'(wr_cnt - base), 32'd30);
        chk("wrap_line23", 32'(tb_mem[23]), 32'h010001);

        // Fill the post-trigger area with distinct samples.
        for (int j = 1; j <= 38; j++) begin
            data_in = 16'h1000 + 16'(j);
            tick();
        end
        chk("post_line24", 32'(tb_mem[24]), 32'h0100AA);
        data_in = 16'h1027;
        tick();
        chk("full_addr", 32'(mem_addr), 32'd62);
        chk("full_wdata", 32'(mem_wdata), 32'h011026);
        chk("full_armed", 32'(armed), 32'h0);
        tick();
        chk("final_we", 32'(mem_we), 32'h1);
        chk("final_addr", 32'(mem_addr), 32'd63);
        chk("final_wdata", 32'(mem_wdata), 32'h000006);
        chk("final_done", 32'(done), 32'h0);
        tick();
        chk("done_flag", 32'(done), 32'h1);
        chk("done_we", 32'(mem_we), 32'h0);
        base = wr_cnt;
        for (int j = 0; j < 5; j++) begin
            data_in = 16'h3000 + 16'(j);
            tick();
        end
        chk("done_no_writes", 32'(wr_cnt - base), 32'h0);
        chk("done_triggered", 32'(triggered), 32'h1);

        // Re-arm from DONE, then masked equality trigger.
        trig_mask = 16'h00FF; trig_value = 16'h0003; trig_mode = 1'b0;
        data_in = 16'h0007;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_done", 32'(done), 32'h0);
        chk("rearm_triggered", 32'(triggered), 32'h0);
        data_in = 16'h0008; tick();
        chk("rearm_addr", 32'(mem_addr), 32'h0);
        chk("rearm_wdata", 32'(mem_wdata), 32'h010007);
        data_in = 16'h0100; tick();
        data_in = 16'h0503; tick();
        chk("mask_trig_flag", 32'(triggered), 32'h1);
        chk("mask_trig_addr", 32'(mem_addr), 32'h2);
        chk("mask_trig_wdata", 32'(mem_wdata), 32'h010100);
        chk("mask_bt_tail", 32'(bt_tail), 32'h2);
        data_in = 16'h0600; tick();
        chk("mask_line24_addr", 32'(mem_addr), 32'd24);
        chk("mask_line24_wdata", 32'(mem_wdata), 32'h010503);

        // Inequality mode: first sample whose low byte is not 03 fires.
        rst = 1'b1; tick(); rst = 1'b0;
        trig_mode = 1'b1;
        data_in = 16'h0103;
        arm = 1'b1; tick(); arm = 1'b0;
        data_in = 16'h0203; tick();
        chk("neq_no_fire", 32'(triggered), 32'h0);
        chk("neq_wdata0", 32'(mem_wdata), 32'h010103);
        data_in = 16'h0204; tick();
        chk("neq_fire", 32'(triggered), 32'h1);
        chk("neq_addr", 32'(mem_addr), 32'h1);
        chk("neq_wdata", 32'(mem_wdata), 32'h010203);
        chk("neq_bt_tail", 32'(bt_tail), 32'h1);

        // Asynchronous reset during the write of line 40.
        for (int j = 1; j <= 17; j++) begin
            data_in = 16'h2000 + 16'(j);
            tick();
        end
        chk("mid_we", 32'(mem_we), 32'h1);
        chk("mid_addr", 32'(mem_addr), 32'd40);
        chk("mid_wdata", 32'(mem_wdata), 32'h012010);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        base = wr_cnt;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            data_in = 16'h4000 + 16'(j);
            tick();
        end
        chk("post_rst_no_writes", 32'(wr_cnt - base), 32'h0);
        chk_all_zero("post_rst_outputs");
        data_in = 16'h0011;
        arm = 1'b1; tick(); arm = 1'b0;
        data_in = 16'h0012; tick();
        chk("rst_rearm_we", 32'(mem_we), 32'h1);
        chk("rst_rearm_addr", 32'(mem_addr), 32'h0);
        chk("rst_rearm_wdata", 32'(mem_wdata), 32'h010011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rle_capture_unit.md
# rle_capture_unit

Parametrised run-length-encoding capture engine for the on-chip logic analyser. It sits between the probed signals and the capture memory. It samples `data_in` every clock and compresses repeated samples into `{count, data}` lines. Before the trigger it keeps a circular before-trigger queue; after the trigger it fills the remaining memory linearly. It finishes by writing the before-trigger tail pointer to the last memory line, where the host-side dump/replay tool reads it back.

## Interface
- `DATA_W`, 16, probed sample width; must be ≥ `ADDR_W`
- `CNT_W`, 8, run-length count field width
- `CNT_MAX`, 253, maximum run length per line; ≤ 2^`CNT_W`−1
- `ADDR_W`, 6, capture memory address width; `LAST` = 2^`ADDR_W`−1
- `BT_LINES`, 24, before-trigger queue depth; lines 0..`BT_LINES`−1; must be < `LAST`−1
- `clk`  in  1  capture clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `arm`  in  1  start capture (single-cycle pulse)
- `data_in`  in  `DATA_W`  probed sample
- `trig_value`  in  `DATA_W`  trigger compare value
- `trig_mask`  in  `DATA_W`  trigger compare mask; 1 = bit compared
- `trig_mode`  in  1  0: fire on `(data_in&mask)==(value&mask)`; 1: fire on inequality
- `mem_we`  out  1  memory write strobe
- `mem_addr`  out  `ADDR_W`  memory write address
- `mem_wdata`  out  `CNT_W+DATA_W`  `{count, data}`
- `armed`  out  1  high in PRE and POST
- `triggered`  out  1  high from trigger until next arm or reset
- `done`  out  1  high in DONE
- `bt_tail`  out  `ADDR_W`  address of the last before-trigger line written

## Operation
- States: IDLE, PRE, POST, FINAL, DONE.
- **Run register.** Holds `cur` (`DATA_W` bits) and `cnt` (`CNT_W` bits). "Flush" means writing `{cnt, cur}` at the current address, then loading `cur`=sample and `cnt`=1.
- **IDLE.**
  - `arm`=1: load `cur`=`data_in`, `cnt`=1, `addr`=0; clear `triggered`; go to PRE.
  - The arm-cycle sample is never tested against the trigger.
- **PRE**, per sample s:
  - Trigger fires on s: flush at `addr`; `bt_tail`←`addr`; the new run is loaded with s; `addr`←`BT_LINES`; `triggered`←1; go to POST. The trigger sample therefore always starts a fresh line.
  - Else if s==`cur` and `cnt`<`CNT_MAX`: `cnt`++.
  - Else flush; `addr` wraps `BT_LINES`−1→0, otherwise increments.
- **POST**, per sample s:
  - The trigger is ignored.
  - If s==`cur` and `cnt`<`CNT_MAX`: `cnt`++.
  - Else flush. If `addr`==`LAST`−1, go to FINAL (the sample is dropped); else `addr`++.
- **FINAL.** Write `{0, zero-extended bt_tail}` at `LAST`; go to DONE.
- **DONE.** No writes; the run register is frozen. `arm` restarts as from IDLE and clears `triggered`/`done`.
- `arm` in PRE, POST or FINAL is ignored.
- A run that saturates at `CNT_MAX` flushes on the next sample, even when the data is unchanged.
- Before-trigger lines never written (trigger before the first wrap) retain stale contents. The host distinguishes them using `bt_tail`.

## Timing
- All outputs are registered.
- `mem_we`/`mem_addr`/`mem_wdata` are valid in the cycle after the clock edge at which the deciding sample was taken; `mem_we` is a one-cycle pulse per line.
- Sustained throughput: at most one line per clock (every sample differs).
- `triggered` rises in the same cycle as the flush write of the last before-trigger line.
- `done` rises in the cycle after the FINAL write.
- `rst` asserted (asynchronous, at any time, including mid-write):
  - all outputs go to 0 immediately, state goes to IDLE, run register cleared;
  - no write completes after assertion.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `armed`=0, `triggered`=0, `done`=0, `bt_tail`=0.

## Test plan
1. Reset, then toggle `data_in` for 50 clocks with no arm → `mem_we` never asserts; all outputs stay 0.
2. Arm with constant 0x0000 for 300 clocks, defaults → line 0 = `{253, 0x0000}`, then the run continues with `cnt` counting up from 1; no other writes.
3. Alternate 0x0001/0x0002 each clock for 30 clocks, then trigger → writes to 0..23, then 0..5 (wrap); the trigger flush lands at the next queue address and `bt_tail` equals it.
4. Mask 0x00FF, value 0x0003, mode 0; drive 0x0100 then 0x0503 → trigger on 0x0503:
   - line 24 later = `{1, 0x0503}` if the next sample differs;
   - with mode 1, the first sample ≠ xx03 fires instead.
5. After the trigger, drive distinct samples until full → writes through line 62; line 63 = `{0, bt_tail}`; `done`=1; further samples produce no writes; a new `arm` restarts at line 0.
6. Assert `rst` for 1 clock mid-POST at line 40 → outputs 0 in the same cycle, no later write; re-arm captures normally from line 0.
